// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC generation, fetch queue, redirect flush
// Define IF_MISALIGN_CHK_EN to add misaligned-redirect detection (misalign_err, fetch halt).
module if_fetch_unit #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    pc,
  output logic               pc_vld,
  input  logic [INSTR_W-1:0] instr,
  input  logic               redirect_vld,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               id_valid,
  output logic [PC_W-1:0]    id_pc,
  output logic [INSTR_W-1:0] id_instr,
  input  logic               id_ready
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic               misalign_err
`endif
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int OCC_W = $clog2(FQ_DEPTH + 1);

  logic [PC_W-1:0]    pc_q;
  logic               inflight_q;
  logic [PC_W-1:0]    inflight_pc_q;
  logic [PC_W-1:0]    q_pc    [FQ_DEPTH];
  logic [INSTR_W-1:0] q_instr [FQ_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [OCC_W-1:0]   occ_q;

  logic               halt;
  logic               push;
  logic               pop;
  logic [OCC_W:0]     demand;
  logic [PC_W-1:0]    redirect_tgt;

`ifdef IF_MISALIGN_CHK_EN
  logic misalign_q;

  // Sticky until an aligned redirect; fetch stays halted meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (redirect_vld) begin
      misalign_q <= |redirect_pc[1:0];
    end
  end

  assign halt         = misalign_q;
  assign misalign_err = misalign_q;
  assign redirect_tgt = redirect_pc;
`else
  logic unused_redirect_lsb;

  assign halt                = 1'b0;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redirect_tgt        = {redirect_pc[PC_W-1:2], 2'b00};
`endif

  assign pop      = id_valid & id_ready;
  assign push     = inflight_q & ~redirect_vld;
  assign pc       = pc_q;
  assign id_valid = (occ_q != '0);
  assign id_pc    = q_pc[rd_ptr_q];
  assign id_instr = q_instr[rd_ptr_q];

  // Count the in-flight word as already occupying a slot so the queue can never overflow.
  assign demand = {1'b0, occ_q} + (OCC_W+1)'(inflight_q) - (OCC_W+1)'(pop);
  assign pc_vld = rst_n & ~redirect_vld & ~halt & (demand < (OCC_W+1)'(FQ_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      occ_q         <= '0;
    end else if (redirect_vld) begin
      pc_q       <= redirect_tgt;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      inflight_q <= pc_vld;
      if (pc_vld) begin
        pc_q          <= pc_q + PC_W'(4);
        inflight_pc_q <= pc_q;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (push) begin
      q_pc[wr_ptr_q]    <= inflight_pc_q;
      q_instr[wr_ptr_q] <= instr;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (occ_q == OCC_W'(FQ_DEPTH))));

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit with an in-order PC scoreboard
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, instr, redirect_pc, id_pc, id_instr;
  logic        pc_vld, redirect_vld, id_valid, id_ready;
  logic [31:0] pc_w, instr_w, id_pc_w, id_instr_w;
  logic        pc_vld_w, id_valid_w;
`ifdef IF_MISALIGN_CHK_EN
  logic        misalign_err, misalign_err_w;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic        sb_en = 1'b0;
  logic [31:0] exp_pc = '0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_pc, hold_instr;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_vld(pc_vld), .instr(instr),
    .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready)
`ifdef IF_MISALIGN_CHK_EN
    , .misalign_err(misalign_err)
`endif
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .pc(pc_w), .pc_vld(pc_vld_w), .instr(instr_w),
    .redirect_vld(1'b0), .redirect_pc(32'h0),
    .id_valid(id_valid_w), .id_pc(id_pc_w), .id_instr(id_instr_w), .id_ready(1'b1)
`ifdef IF_MISALIGN_CHK_EN
    , .misalign_err(misalign_err_w)
`endif
  );

  // Instruction RAM: word at address a holds a>>2; unrequested cycles return noise.
  always @(posedge clk) begin
    instr   <= pc_vld   ? (pc   >> 2) : $urandom;
    instr_w <= pc_vld_w ? (pc_w >> 2) : $urandom;
  end

  // One clock: drive inputs on the falling edge, then score the settled outputs.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    id_ready = rdy; redirect_vld = rv; redirect_pc = rpc;
    #1;
    if (sb_en && rst_n) begin
      if (hold_pend) begin
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== hold_pc || id_instr !== hold_instr) begin
          n_errors++;
          $display("FAIL hold_stable: got valid=%b pc=%h instr=%h want 1 %h %h", id_valid, id_pc, id_instr, hold_pc, hold_instr);
        end
      end
      if (id_valid === 1'b1 && id_ready === 1'b1) begin
        n_checks++;
        if (id_pc !== exp_pc || id_instr !== (exp_pc >> 2)) begin
          n_errors++;
          $display("FAIL in_order: got pc=%h instr=%h want pc=%h instr=%h", id_pc, id_instr, exp_pc, exp_pc >> 2);
        end
        exp_pc = exp_pc + 32'd4;
      end
      hold_pend  = (id_valid === 1'b1 && id_ready === 1'b0);
      hold_pc    = id_pc;
      hold_instr = id_instr;
      if (rv) begin
        hold_pend = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
        exp_pc = rpc;
`else
        exp_pc = {rpc[31:2], 2'b00};
`endif
      end
    end else begin
      hold_pend = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    sb_en = 1'b0; rst_n = 1'b0; id_ready = 1'b0; redirect_vld = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset(input logic rdy);
    @(negedge clk);
    exp_pc = '0; hold_pend = 1'b0; sb_en = 1'b1;
    rst_n = 1'b1; id_ready = rdy; redirect_vld = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++; if (pc_vld !== 1'b0) begin n_errors++; $display("FAIL reset_pc_vld: got %b want 0", pc_vld); end
    n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got %h want 0", pc); end
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
    n_checks++; if (id_pc !== 32'h0 || id_instr !== 32'h0) begin n_errors++; $display("FAIL reset_id_data: got %h/%h want 0/0", id_pc, id_instr); end
    n_checks++; if (pc_w !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL reset_pc_w: got %h want fffffffc", pc_w); end
  endtask

  task automatic test_stream();
    int gaps = 0;
    release_reset(1'b1);
    n_checks++; if (pc_vld !== 1'b1 || pc !== 32'h0) begin n_errors++; $display("FAIL first_fetch: got vld=%b pc=%h want 1 0", pc_vld, pc); end
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL c1_id_valid: got %b want 0", id_valid); end
    step(1'b1, 1'b0, '0);
    n_checks++; if (id_valid !== 1'b0 || pc !== 32'h4) begin n_errors++; $display("FAIL c2: got valid=%b pc=%h want 0 4", id_valid, pc); end
    step(1'b1, 1'b0, '0);
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h0) begin n_errors++; $display("FAIL c3_first_out: got valid=%b pc=%h instr=%h want 1 0 0", id_valid, id_pc, id_instr); end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, '0);
      if (id_valid !== 1'b1) gaps++;
    end
    n_checks++; if (gaps != 0) begin n_errors++; $display("FAIL stream_gaps: got %0d want 0", gaps); end
  endtask

  task automatic test_stall();
    int fetches = 0, bad_pc = 0, gaps = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, '0);
      if (pc_vld === 1'b1) fetches++;
      if (pc !== id_pc + 32'd8) bad_pc++;
    end
    n_checks++; if (fetches != 0) begin n_errors++; $display("FAIL stall_fetches: got %0d want 0", fetches); end
    n_checks++; if (bad_pc != 0) begin n_errors++; $display("FAIL stall_pc_held: got %0d bad cycles want 0", bad_pc); end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, '0);
      if (id_valid !== 1'b1) gaps++;
    end
    n_checks++; if (gaps != 0) begin n_errors++; $display("FAIL resume_gaps: got %0d want 0", gaps); end
  endtask

  task automatic test_redirect();
    logic found = 1'b0;
    apply_reset();
    release_reset(1'b1);
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b0, '0);
      if (pc === 32'h14) found = 1'b1;
    end
    n_checks++; if (!found) begin n_errors++; $display("FAIL redir_setup: got pc=%h want 14", pc); end
    step(1'b0, 1'b1, 32'h40);
    n_checks++; if (pc_vld !== 1'b0) begin n_errors++; $display("FAIL redir_pc_vld: got %b want 0", pc_vld); end
    step(1'b0, 1'b0, '0);
    n_checks++; if (pc !== 32'h40 || pc_vld !== 1'b1 || id_valid !== 1'b0) begin n_errors++; $display("FAIL redir_r1: got pc=%h vld=%b idv=%b want 40 1 0", pc, pc_vld, id_valid); end
    step(1'b0, 1'b0, '0);
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL redir_r2: got %b want 0", id_valid); end
    step(1'b1, 1'b0, '0);
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== 32'h10) begin n_errors++; $display("FAIL redir_r3: got valid=%b pc=%h instr=%h want 1 40 10", id_valid, id_pc, id_instr); end
    repeat (4) step(1'b1, 1'b0, '0);
  endtask

  task automatic test_redirect_pop();
    repeat (4) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 32'h100);
    n_checks++; if (id_valid !== 1'b1) begin n_errors++; $display("FAIL rpop_head: got %b want 1", id_valid); end
    step(1'b1, 1'b0, '0);
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL rpop_flushed: got %b want 0", id_valid); end
    step(1'b1, 1'b0, '0);
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL rpop_r2: got %b want 0", id_valid); end
    step(1'b1, 1'b0, '0);
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin n_errors++; $display("FAIL rpop_target: got valid=%b pc=%h want 1 100", id_valid, id_pc); end
    repeat (3) step(1'b1, 1'b0, '0);
  endtask

  task automatic test_wrap();
    apply_reset();
    release_reset(1'b1);
    n_checks++; if (pc_w !== 32'hFFFF_FFFC || pc_vld_w !== 1'b1) begin n_errors++; $display("FAIL wrap_c1: got %h vld=%b want fffffffc 1", pc_w, pc_vld_w); end
    step(1'b1, 1'b0, '0);
    n_checks++; if (pc_w !== 32'h0) begin n_errors++; $display("FAIL wrap_c2: got %h want 0", pc_w); end
    step(1'b1, 1'b0, '0);
    n_checks++; if (pc_w !== 32'h4 || id_valid_w !== 1'b1 || id_pc_w !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_c3: got pc=%h idv=%b idpc=%h want 4 1 fffffffc", pc_w, id_valid_w, id_pc_w); end
    step(1'b1, 1'b0, '0);
    n_checks++; if (id_pc_w !== 32'h0 || id_instr_w !== 32'h0) begin n_errors++; $display("FAIL wrap_c4: got %h/%h want 0/0", id_pc_w, id_instr_w); end
  endtask

  task automatic test_misalign();
    apply_reset();
    release_reset(1'b1);
    repeat (5) step(1'b1, 1'b0, '0);
`ifdef IF_MISALIGN_CHK_EN
    begin
      int bad = 0;
      step(1'b1, 1'b1, 32'h42);
      for (int i = 0; i < 4; i++) begin
        step(1'b1, 1'b0, '0);
        if (misalign_err !== 1'b1 || pc_vld !== 1'b0 || id_valid !== 1'b0) bad++;
      end
      n_checks++; if (bad != 0) begin n_errors++; $display("FAIL misalign_halt: got %0d bad cycles want 0", bad); end
      step(1'b1, 1'b1, 32'h80);
      step(1'b1, 1'b0, '0);
      n_checks++; if (misalign_err !== 1'b0 || pc !== 32'h80 || pc_vld !== 1'b1) begin n_errors++; $display("FAIL misalign_clear: got err=%b pc=%h vld=%b want 0 80 1", misalign_err, pc, pc_vld); end
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h80) begin n_errors++; $display("FAIL misalign_resume: got valid=%b pc=%h want 1 80", id_valid, id_pc); end
    end
`else
    step(1'b1, 1'b1, 32'h43);
    step(1'b1, 1'b0, '0);
    n_checks++; if (pc !== 32'h40) begin n_errors++; $display("FAIL lsb_forced: got %h want 40", pc); end
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h40) begin n_errors++; $display("FAIL lsb_target: got valid=%b pc=%h want 1 40", id_valid, id_pc); end
`endif
    repeat (3) step(1'b1, 1'b0, '0);
  endtask

  task automatic test_async_reset();
    repeat (3) step(1'b0, 1'b0, '0);
    @(negedge clk);
    #3;
    sb_en = 1'b0; rst_n = 1'b0;
    #1;
    n_checks++; if (pc !== 32'h0 || pc_vld !== 1'b0) begin n_errors++; $display("FAIL async_pc: got %h vld=%b want 0 0", pc, pc_vld); end
    n_checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0) begin n_errors++; $display("FAIL async_id: got %b %h %h want 0 0 0", id_valid, id_pc, id_instr); end
`ifdef IF_MISALIGN_CHK_EN
    n_checks++; if (misalign_err !== 1'b0) begin n_errors++; $display("FAIL async_misalign: got %b want 0", misalign_err); end
`endif
  endtask

  task automatic test_random();
    int pops = 0;
    apply_reset();
    release_reset(1'b1);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom & 32'h0000_FFFC);
      if (id_valid === 1'b1 && id_ready === 1'b1) pops++;
    end
    n_checks++; if (pops < 50) begin n_errors++; $display("FAIL random_progress: got %0d pops want >=50", pops); end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; id_ready = 1'b0; redirect_vld = 1'b0; redirect_pc = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_misalign();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
